// File: rtl/gemm_result_drain_pkg.sv
// Shared sizes, result_valid bit positions and drain FSM state type.
package gemm_result_drain_pkg;

  localparam int unsigned S2P_SIZE    = 4;
  localparam int unsigned RESULT_SIZE = 32;

  // result_valid bit positions
  localparam int unsigned RV_VLD   = 0;
  localparam int unsigned RV_ACT   = 1;
  localparam int unsigned RV_FIRST = 2;
  localparam int unsigned RV_GLAST = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StDone
  } drain_st_e;

endpackage

// File: rtl/gemm_result_drain_tile_fifo2.sv
// Two-entry register FIFO holding whole tiles plus their grp_last/conv_last flags.
module gemm_result_drain_tile_fifo2 #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [DataW-1:0] data_i,
  input  logic             grp_last_i,
  input  logic             conv_last_i,
  input  logic             pop_i,
  output logic [DataW-1:0] head_data_o,
  output logic             head_grp_last_o,
  output logic             head_conv_last_o,
  output logic [1:0]       count_o,
  output logic [1:0]       count_nxt_o
);

  logic [DataW-1:0] data_q [2];
  logic [1:0]       grp_q;
  logic [1:0]       conv_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy; reset flushes all entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) data_q[i] <= '0;
      grp_q    <= '0;
      conv_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= data_i;
        grp_q[wr_ptr_q]  <= grp_last_i;
        conv_q[wr_ptr_q] <= conv_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head_data_o      = data_q[rd_ptr_q];
  assign head_grp_last_o  = grp_q[rd_ptr_q];
  assign head_conv_last_o = conv_q[rd_ptr_q];
  assign count_o          = count_q;
  assign count_nxt_o      = count_d;

endmodule

// File: rtl/gemm_result_drain.sv
// Serialises buffered GEMM tiles into a kernel-major word stream with framing and conv_done.
module gemm_result_drain
  import gemm_result_drain_pkg::*;
#(
  parameter int unsigned S2P   = S2P_SIZE,
  parameter int unsigned KROWS = 4,
  parameter int unsigned RES_W = RESULT_SIZE
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       tile_vld_i,
  output logic                       tile_rdy_o,
  input  logic [KROWS*S2P*RES_W-1:0] tile_data_i,
  input  logic                       tile_grp_last_i,
  input  logic                       tile_conv_last_i,
  output logic [RES_W-1:0]           result_o,
  output logic [3:0]                 result_valid_o,
  output logic                       conv_done_o
);

  localparam int unsigned Words = KROWS * S2P;
  localparam int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1;
  localparam int unsigned TileW = Words * RES_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  logic             push;
  logic             pop;
  logic [TileW-1:0] head_data;
  logic             head_glast;
  logic             head_clast;
  logic [1:0]       count;
  logic [1:0]       count_nxt;
  logic [RES_W-1:0] head_word;

  drain_st_e        state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [3:0]       rv_q, rv_d;
  logic             done_q, done_d;
  logic             rdy_q;

  assign push = tile_vld_i & rdy_q;

  gemm_result_drain_tile_fifo2 #(
    .DataW (TileW)
  ) u_fifo (
    .clk              (clk),
    .rstn             (rstn),
    .push_i           (push),
    .data_i           (tile_data_i),
    .grp_last_i       (tile_grp_last_i),
    .conv_last_i      (tile_conv_last_i),
    .pop_i            (pop),
    .head_data_o      (head_data),
    .head_grp_last_o  (head_glast),
    .head_conv_last_o (head_clast),
    .count_o          (count),
    .count_nxt_o      (count_nxt)
  );

  assign head_word = head_data[32'(idx_q) * RES_W +: RES_W];

  // Drain FSM: next state, idx counter, pop and next output values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    result_d = result_q;
    rv_d     = 4'b0000;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count != 2'd0) begin
          state_d = StDrain;
          idx_d   = '0;
        end
      end
      StDrain: begin
        result_d         = head_word;
        rv_d[RV_VLD]     = 1'b1;
        rv_d[RV_ACT]     = 1'b1;
        rv_d[RV_FIRST]   = (idx_q == '0);
        rv_d[RV_GLAST]   = (idx_q == '0) & head_glast;
        if (idx_q == LastIdx) begin
          pop   = 1'b1;
          idx_d = '0;
          if (head_clast)           state_d = StDone;
          // Second tile already buffered: continue without a bubble.
          else if (count == 2'd2)   state_d = StDrain;
          else                      state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter and registered outputs; tile_rdy follows next occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      result_q <= '0;
      rv_q     <= 4'b0000;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
      rdy_q    <= (count_nxt != 2'd2);
    end
  end

  assign tile_rdy_o     = rdy_q;
  assign result_o       = result_q;
  assign result_valid_o = rv_q;
  assign conv_done_o    = done_q;

endmodule

// File: tb/tb_gemm_result_drain.sv
// Directed bench for gemm_result_drain with S2P=4, KROWS=2, RES_W=32 (8 words per tile).
module tb_gemm_result_drain;

  localparam int unsigned S2P   = 4;
  localparam int unsigned KROWS = 2;
  localparam int unsigned RES_W = 32;
  localparam int unsigned TileW = S2P * KROWS * RES_W;

  logic             clk;
  logic             rstn;
  logic             tile_vld;
  logic             tile_rdy;
  logic [TileW-1:0] tile_data;
  logic             tile_grp_last;
  logic             tile_conv_last;
  logic [RES_W-1:0] result;
  logic [3:0]       result_valid;
  logic             conv_done;

  int n_total = 0;
  int n_pass  = 0;
  int done_seen = 0;

  gemm_result_drain #(
    .S2P   (S2P),
    .KROWS (KROWS),
    .RES_W (RES_W)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .tile_vld_i       (tile_vld),
    .tile_rdy_o       (tile_rdy),
    .tile_data_i      (tile_data),
    .tile_grp_last_i  (tile_grp_last),
    .tile_conv_last_i (tile_conv_last),
    .result_o         (result),
    .result_valid_o   (result_valid),
    .conv_done_o      (conv_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TileW-1:0] mk_tile(input logic [31:0] base);
    logic [TileW-1:0] t;
    for (int j = 0; j < 8; j++) t[j*32 +: 32] = base + 32'(j);
    return t;
  endfunction

  task automatic push(input logic [TileW-1:0] t, input logic g, input logic c);
    tile_data      = t;
    tile_grp_last  = g;
    tile_conv_last = c;
    tile_vld       = 1'b1;
  endtask

  // Expects word 0 already visible; leaves the bench on word 7.
  task automatic drain_check(input string tag, input logic [TileW-1:0] t, input logic g);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      check({tag, "_word"}, result, t[j*32 +: 32]);
      check({tag, "_rv"}, {28'd0, result_valid}, (j == 0) ? {28'd0, g, 3'b111} : 32'h3);
    end
  endtask

  task automatic done_check(input string tag);
    step();
    check({tag, "_done_rv"}, {28'd0, result_valid}, 32'h0);
    check({tag, "_done"}, {31'd0, conv_done}, 32'h1);
    step();
    check({tag, "_done_off"}, {31'd0, conv_done}, 32'h0);
  endtask

  // conv_done must never coincide with a valid word; also count pulses.
  always @(negedge clk) begin
    if (rstn && conv_done) begin
      done_seen++;
      check("done_excl", {31'd0, result_valid[0]}, 32'h0);
    end
  end

  initial begin
    logic [TileW-1:0] ta, tb, tc, td, te, ts, tf, tg;
    rstn           = 1'b0;
    tile_vld       = 1'b0;
    tile_data      = '0;
    tile_grp_last  = 1'b0;
    tile_conv_last = 1'b0;

    repeat (2) step();
    check("rst_rdy", {31'd0, tile_rdy}, 32'h0);
    check("rst_rv", {28'd0, result_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_done", {31'd0, conv_done}, 32'h0);
    rstn = 1'b1;
    step();
    check("post_rst_rdy", {31'd0, tile_rdy}, 32'h1);

    // Single tile, words 0..7, conv_last.
    ta = mk_tile(32'd0);
    push(ta, 1'b0, 1'b1);
    step();
    tile_vld = 1'b0;
    step();
    check("single_lat_rv", {28'd0, result_valid}, 32'h0);
    step();
    drain_check("single", ta, 1'b0);
    done_check("single");

    // Two tiles back-to-back.
    ta = mk_tile(32'd0);
    tb = mk_tile(32'd100);
    push(ta, 1'b1, 1'b0);
    step();
    push(tb, 1'b0, 1'b1);
    step();
    tile_vld = 1'b0;
    check("two_full_rdy", {31'd0, tile_rdy}, 32'h0);
    step();
    drain_check("twoA", ta, 1'b1);
    step();
    drain_check("twoB", tb, 1'b0);
    done_check("two");

    // Three tiles with tile_vld held high.
    tc = mk_tile(32'd200);
    td = mk_tile(32'd300);
    te = mk_tile(32'd400);
    push(tc, 1'b0, 1'b0);
    step();
    push(td, 1'b0, 1'b0);
    step();
    push(te, 1'b0, 1'b1);
    check("three_rdy_low", {31'd0, tile_rdy}, 32'h0);
    step();
    drain_check("threeC", tc, 1'b0);
    check("three_rdy_after_pop", {31'd0, tile_rdy}, 32'h1);
    step();
    tile_vld = 1'b0;
    check("three_rdy_full_again", {31'd0, tile_rdy}, 32'h0);
    drain_check("threeD", td, 1'b0);
    step();
    drain_check("threeE", te, 1'b0);
    done_check("three");

    // Signed extremes pass bit-exact.
    ts = mk_tile(32'd0);
    ts[0*32 +: 32] = 32'hFFFF_FFFF;
    ts[1*32 +: 32] = 32'h7FFF_FFFF;
    ts[2*32 +: 32] = 32'h8000_0000;
    push(ts, 1'b1, 1'b1);
    step();
    tile_vld = 1'b0;
    step();
    step();
    drain_check("signed", ts, 1'b1);
    done_check("signed");

    // Reset at idx 3 aborts the stream with no conv_done.
    tf = mk_tile(32'd600);
    push(tf, 1'b0, 1'b1);
    step();
    tile_vld = 1'b0;
    repeat (5) step();
    check("abort_w3", result, 32'd603);
    #2 rstn = 1'b0;
    #1;
    check("abort_rv", {28'd0, result_valid}, 32'h0);
    check("abort_done", {31'd0, conv_done}, 32'h0);
    check("abort_rdy", {31'd0, tile_rdy}, 32'h0);
    step();
    step();
    rstn = 1'b1;
    step();
    check("abort_rdy_rel", {31'd0, tile_rdy}, 32'h1);
    check("abort_rv_rel", {28'd0, result_valid}, 32'h0);
    tg = mk_tile(32'd500);
    push(tg, 1'b0, 1'b1);
    step();
    tile_vld = 1'b0;
    step();
    step();
    drain_check("after_rst", tg, 1'b0);
    done_check("after_rst");

    // Idle gap: nothing queued, nothing emitted.
    for (int i = 0; i < 12; i++) begin
      step();
      check("idle_rv", {28'd0, result_valid}, 32'h0);
      check("idle_done", {31'd0, conv_done}, 32'h0);
    end

    check("done_count", done_seen, 32'd5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
